// File: rtl/freecell_pkg.sv
// Shared types and helpers for the freecell engine.
//   card_t      : packed card {suit, rank}; rank 0 marks an empty slot
//   sel_kind_e  : classification of a source/destination selector code
//   state_e     : engine operating state
package freecell_pkg;

   localparam int unsigned SUIT_W = 2;
   localparam int unsigned RANK_W = 4;

   localparam logic [SUIT_W-1:0] SUIT_CLUBS    = 2'd0;
   localparam logic [SUIT_W-1:0] SUIT_DIAMONDS = 2'd1;
   localparam logic [SUIT_W-1:0] SUIT_HEARTS   = 2'd2;
   localparam logic [SUIT_W-1:0] SUIT_SPADES   = 2'd3;

   localparam logic [RANK_W-1:0] RANK_EMPTY = 4'd0;
   localparam logic [RANK_W-1:0] RANK_KING  = 4'd13;

   typedef struct packed {
      logic [SUIT_W-1:0] suit;
      logic [RANK_W-1:0] rank;
   } card_t;

   typedef enum logic [1:0] {
      KIND_COL,
      KIND_CELL,
      KIND_HOME,
      KIND_BAD
   } sel_kind_e;

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_PLAY,
      ST_WIN
   } state_e;

   // Diamonds and hearts are the red suits.
   function automatic logic is_red(input card_t c);
      return c.suit[0] ^ c.suit[1];
   endfunction

   // Columns first, then cells, then the single home code; anything above is bad.
   function automatic sel_kind_e sel_kind(input int unsigned sel,
                                          input int unsigned n_cols,
                                          input int unsigned n_cells);
      if (sel < n_cols)
         return KIND_COL;
      else if (sel < n_cols + n_cells)
         return KIND_CELL;
      else if (sel == n_cols + n_cells)
         return KIND_HOME;
      else
         return KIND_BAD;
   endfunction

endpackage

// File: rtl/freecell_rule_check.sv
// Combinational destination-legality decode for a single-card move.
//   i_src_card  : card being moved (assumed present)
//   i_dst_top   : top card of destination column / content of destination cell
//   i_dst_empty : destination column or cell holds no card
//   i_dst_full  : destination column is at maximum depth
//   i_home_cnt  : current home count for the moving card's suit
//   i_dst_kind  : classification of the destination code
//   o_legal_c   : destination accepts the card
module freecell_rule_check
   import freecell_pkg::*;
(
   input  card_t       i_src_card,
   input  card_t       i_dst_top,
   input  logic        i_dst_empty,
   input  logic        i_dst_full,
   input  logic [3:0]  i_home_cnt,
   input  sel_kind_e   i_dst_kind,
   output logic        o_legal_c
);

   always_comb begin
      o_legal_c = 1'b0;
      case (i_dst_kind)
         KIND_HOME: o_legal_c = (i_src_card.rank == i_home_cnt + 4'd1);
         KIND_CELL: o_legal_c = i_dst_empty;
         // A full column can never grow, even onto a matching top card.
         KIND_COL:  o_legal_c = !i_dst_full &&
                                (i_dst_empty ||
                                 ((i_dst_top.rank == i_src_card.rank + 4'd1) &&
                                  (is_red(i_dst_top) != is_red(i_src_card))));
         default:   o_legal_c = 1'b0;
      endcase
   end

endmodule

// File: rtl/freecell_engine.sv
// Parametrised freecell board: run-time deal loading, single-card moves
// with legal/illegal reporting, saturating move counter and win detection.
//   clock, reset       : rising-edge clock, async active-high reset
//   load_valid/col/card: push a card onto a column (LOAD state only)
//   start              : LOAD -> PLAY
//   move_valid/source/dest : one move per cycle (PLAY state only)
//   move_ok/move_illegal/load_err : registered result pulses
//   move_count         : legal moves applied, saturating
//   win                : high while in WIN state (one cycle after entry)
module freecell_engine
   import freecell_pkg::*;
#(
   parameter int unsigned N_COLS  = 8,
   parameter int unsigned N_CELLS = 4,
   parameter int unsigned DEPTH   = 20,
   parameter int unsigned CNT_W   = 10,
   parameter int unsigned SEL_W   = $clog2(N_COLS + N_CELLS + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load_valid,
   input  logic [SEL_W-1:0] load_col,
   input  logic [5:0]       load_card,
   input  logic             start,
   input  logic             move_valid,
   input  logic [SEL_W-1:0] source,
   input  logic [SEL_W-1:0] dest,
   output logic             move_ok,
   output logic             move_illegal,
   output logic             load_err,
   output logic [CNT_W-1:0] move_count,
   output logic             win
);

   localparam int unsigned COL_IW  = (N_COLS  > 1) ? $clog2(N_COLS)  : 1;
   localparam int unsigned CELL_IW = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
   localparam int unsigned DI_W    = (DEPTH   > 1) ? $clog2(DEPTH)   : 1;
   localparam int unsigned H_W     = $clog2(DEPTH + 1);

   // Board storage
   card_t            r_col    [N_COLS][DEPTH];
   logic [H_W-1:0]   r_height [N_COLS];
   card_t            r_cell   [N_CELLS];
   logic [3:0]       r_home   [4];

   state_e           r_state;
   state_e           w_state_nxt;

   logic             r_move_ok;
   logic             r_move_illegal;
   logic             r_load_err;
   logic [CNT_W-1:0] r_count;
   logic             r_win;

   // Decode wires
   card_t               w_load_card;
   logic [COL_IW-1:0]   w_load_ci;
   logic                w_load_ok;

   sel_kind_e           w_src_kind;
   sel_kind_e           w_dst_kind;
   logic [COL_IW-1:0]   w_src_ci;
   logic [COL_IW-1:0]   w_dst_ci;
   logic [CELL_IW-1:0]  w_src_ki;
   logic [CELL_IW-1:0]  w_dst_ki;

   card_t               w_src_card;
   logic                w_src_valid;
   card_t               w_dst_top;
   logic                w_dst_empty;
   logic                w_dst_full;
   logic                w_rule_legal;
   logic                w_legal;
   logic                w_all_home;

   logic                w_do_load;
   logic                w_load_err_nxt;
   logic                w_do_move;
   logic                w_illegal_nxt;

   assign move_ok      = r_move_ok;
   assign move_illegal = r_move_illegal;
   assign load_err     = r_load_err;
   assign move_count   = r_count;
   assign win          = r_win;

   // Load acceptance
   assign w_load_card = card_t'(load_card);
   assign w_load_ci   = COL_IW'(load_col);

   always_comb begin
      w_load_ok = (32'(load_col) < N_COLS) &&
                  (r_height[w_load_ci] != H_W'(DEPTH)) &&
                  (w_load_card.rank != RANK_EMPTY) &&
                  (w_load_card.rank <= RANK_KING);
   end

   // Selector decode; truncated indices are only used when the kind matches
   assign w_src_kind = sel_kind(32'(source), N_COLS, N_CELLS);
   assign w_dst_kind = sel_kind(32'(dest),   N_COLS, N_CELLS);
   assign w_src_ci   = COL_IW'(source);
   assign w_dst_ci   = COL_IW'(dest);
   assign w_src_ki   = CELL_IW'(32'(source) - N_COLS);
   assign w_dst_ki   = CELL_IW'(32'(dest)   - N_COLS);

   // Source card: column top or cell content
   always_comb begin
      w_src_card = '0;
      case (w_src_kind)
         KIND_COL: begin
            if (r_height[w_src_ci] != '0)
               w_src_card = r_col[w_src_ci][DI_W'(r_height[w_src_ci] - H_W'(1))];
         end
         KIND_CELL: w_src_card = r_cell[w_src_ki];
         default:   ;
      endcase
   end

   assign w_src_valid = ((w_src_kind == KIND_COL) || (w_src_kind == KIND_CELL)) &&
                        (w_src_card.rank != RANK_EMPTY);

   // Destination view for the rule checker
   always_comb begin
      w_dst_top   = '0;
      w_dst_empty = 1'b0;
      w_dst_full  = 1'b0;
      case (w_dst_kind)
         KIND_COL: begin
            w_dst_empty = (r_height[w_dst_ci] == '0);
            w_dst_full  = (r_height[w_dst_ci] == H_W'(DEPTH));
            if (!w_dst_empty)
               w_dst_top = r_col[w_dst_ci][DI_W'(r_height[w_dst_ci] - H_W'(1))];
         end
         KIND_CELL: begin
            w_dst_top   = r_cell[w_dst_ki];
            w_dst_empty = (r_cell[w_dst_ki].rank == RANK_EMPTY);
         end
         default: ;
      endcase
   end

   freecell_rule_check u_rule_check (
      .i_src_card  (w_src_card),
      .i_dst_top   (w_dst_top),
      .i_dst_empty (w_dst_empty),
      .i_dst_full  (w_dst_full),
      .i_home_cnt  (r_home[w_src_card.suit]),
      .i_dst_kind  (w_dst_kind),
      .o_legal_c   (w_rule_legal)
   );

   assign w_legal = w_src_valid && (source != dest) && w_rule_legal;

   // True when a home move of the source card would complete all four suits
   always_comb begin
      w_all_home = 1'b1;
      for (int s = 0; s < 4; s++) begin
         if (2'(s) == w_src_card.suit)
            w_all_home = w_all_home && (r_home[s] + 4'd1 == RANK_KING);
         else
            w_all_home = w_all_home && (r_home[s] == RANK_KING);
      end
   end

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_state <= ST_LOAD;
      else
         r_state <= w_state_nxt;
   end

   // Next state and per-cycle actions
   always_comb begin
      w_state_nxt    = r_state;
      w_do_load      = 1'b0;
      w_load_err_nxt = 1'b0;
      w_do_move      = 1'b0;
      w_illegal_nxt  = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (load_valid) begin
               if (w_load_ok)
                  w_do_load = 1'b1;
               else
                  w_load_err_nxt = 1'b1;
            end
            if (start)
               w_state_nxt = ST_PLAY;
         end
         ST_PLAY: begin
            if (move_valid) begin
               if (w_legal) begin
                  w_do_move = 1'b1;
                  if ((w_dst_kind == KIND_HOME) && w_all_home)
                     w_state_nxt = ST_WIN;
               end else begin
                  w_illegal_nxt = 1'b1;
               end
            end
         end
         ST_WIN:  ;
         default: w_state_nxt = ST_LOAD;
      endcase
   end

   // Pulses, counters, heights, cells and home counts
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_move_ok      <= 1'b0;
         r_move_illegal <= 1'b0;
         r_load_err     <= 1'b0;
         r_count        <= '0;
         r_win          <= 1'b0;
         for (int c = 0; c < N_COLS; c++)
            r_height[c] <= '0;
         for (int k = 0; k < N_CELLS; k++)
            r_cell[k] <= '0;
         for (int s = 0; s < 4; s++)
            r_home[s] <= '0;
      end else begin
         r_move_ok      <= w_do_move;
         r_move_illegal <= w_illegal_nxt;
         r_load_err     <= w_load_err_nxt;
         r_win          <= (r_state == ST_WIN);

         if (w_do_load)
            r_height[w_load_ci] <= r_height[w_load_ci] + H_W'(1);

         if (w_do_move) begin
            if (r_count != '1)
               r_count <= r_count + CNT_W'(1);

            // source != dest, so the two updates never target the same slot
            case (w_src_kind)
               KIND_COL:  r_height[w_src_ci] <= r_height[w_src_ci] - H_W'(1);
               KIND_CELL: r_cell[w_src_ki]   <= '0;
               default:   ;
            endcase

            case (w_dst_kind)
               KIND_COL:  r_height[w_dst_ci] <= r_height[w_dst_ci] + H_W'(1);
               KIND_CELL: r_cell[w_dst_ki]   <= w_src_card;
               KIND_HOME: r_home[w_src_card.suit] <= r_home[w_src_card.suit] + 4'd1;
               default:   ;
            endcase
         end
      end
   end

   // Column card storage; validity is tracked entirely by r_height
   always_ff @(posedge clock) begin
      if (w_do_load)
         r_col[w_load_ci][DI_W'(r_height[w_load_ci])] <= w_load_card;
      else if (w_do_move && (w_dst_kind == KIND_COL))
         r_col[w_dst_ci][DI_W'(r_height[w_dst_ci])] <= w_src_card;
   end

endmodule

// File: tb/tb_freecell_engine.sv
// Self-checking bench for freecell_engine on a 4-column, 2-cell, depth-13 board.
module tb_freecell_engine;

   localparam int unsigned NC  = 4;
   localparam int unsigned NK  = 2;
   localparam int unsigned DEP = 13;
   localparam int unsigned CW  = 10;
   localparam int unsigned SW  = 3;
   localparam int          HOME = NC + NK;
   localparam int          CNT_MAX = (1 << CW) - 1;

   logic          clock;
   logic          reset;
   logic          load_valid;
   logic [SW-1:0] load_col;
   logic [5:0]    load_card;
   logic          start;
   logic          move_valid;
   logic [SW-1:0] source;
   logic [SW-1:0] dest;
   logic          move_ok;
   logic          move_illegal;
   logic          load_err;
   logic [CW-1:0] move_count;
   logic          win;

   freecell_engine #(
      .N_COLS  (NC),
      .N_CELLS (NK),
      .DEPTH   (DEP),
      .CNT_W   (CW),
      .SEL_W   (SW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .load_valid   (load_valid),
      .load_col     (load_col),
      .load_card    (load_card),
      .start        (start),
      .move_valid   (move_valid),
      .source       (source),
      .dest         (dest),
      .move_ok      (move_ok),
      .move_illegal (move_illegal),
      .load_err     (load_err),
      .move_count   (move_count),
      .win          (win)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Reference board: cards as integers (suit*16 + rank), 0 = empty
   int m_col  [NC][64];
   int m_h    [NC];
   int m_cell [NK];
   int m_home [4];
   int m_state;            // 0 load, 1 play, 2 win
   int m_count;

   int n_tests;
   int n_fail;

   int deck [52];
   int rj, rt, rs, rd, rc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input int e_ok, input int e_ill,
                            input int e_lerr, input int e_win);
      check({tag, ".move_ok"},      32'(move_ok),      32'(e_ok));
      check({tag, ".move_illegal"}, 32'(move_illegal), 32'(e_ill));
      check({tag, ".load_err"},     32'(load_err),     32'(e_lerr));
      check({tag, ".move_count"},   32'(move_count),   32'(m_count));
      check({tag, ".win"},          32'(win),          32'(e_win));
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   function automatic bit red_m(input int c);
      int su;
      su = c >> 4;
      return (su == 1) || (su == 2);
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < NC; i++) m_h[i] = 0;
      for (int i = 0; i < NK; i++) m_cell[i] = 0;
      for (int i = 0; i < 4; i++)  m_home[i] = 0;
      m_state = 0;
      m_count = 0;
   endfunction

   // Applies the move to the reference board if the rules allow it
   function automatic bit model_move(input int s, input int d);
      int c;
      int top;
      bit ok;
      if (s == d) return 1'b0;
      if (s < NC) begin
         if (m_h[s] == 0) return 1'b0;
         c = m_col[s][m_h[s] - 1];
      end else if (s < NC + NK) begin
         c = m_cell[s - NC];
         if (c == 0) return 1'b0;
      end else begin
         return 1'b0;
      end
      if (d == HOME)
         ok = ((c & 15) == m_home[c >> 4] + 1);
      else if (d >= NC && d < NC + NK)
         ok = (m_cell[d - NC] == 0);
      else if (d < NC) begin
         if (m_h[d] == 0)
            ok = 1'b1;
         else if (m_h[d] >= DEP)
            ok = 1'b0;
         else begin
            top = m_col[d][m_h[d] - 1];
            ok = ((top & 15) == (c & 15) + 1) && (red_m(top) != red_m(c));
         end
      end else
         ok = 1'b0;
      if (!ok) return 1'b0;
      if (s < NC) m_h[s]--;
      else        m_cell[s - NC] = 0;
      if (d == HOME)    m_home[c >> 4]++;
      else if (d >= NC) m_cell[d - NC] = c;
      else begin
         m_col[d][m_h[d]] = c;
         m_h[d]++;
      end
      return 1'b1;
   endfunction

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      #1;
      model_reset();
      check_all("reset", 0, 0, 0, 0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic do_load(input int col, input int card);
      int e_err;
      int e_win;
      e_err = 0;
      e_win = (m_state == 2);
      if (m_state == 0) begin
         if (col >= NC || (card & 15) == 0 || (card & 15) > 13)
            e_err = 1;
         else if (m_h[col] >= DEP)
            e_err = 1;
         else begin
            m_col[col][m_h[col]] = card;
            m_h[col]++;
         end
      end
      load_valid = 1'b1;
      load_col   = SW'(col);
      load_card  = 6'(card);
      tick();
      load_valid = 1'b0;
      check_all($sformatf("load c%0d k%0h", col, card), 0, 0, e_err, e_win);
   endtask

   task automatic do_start();
      int e_win;
      e_win = (m_state == 2);
      if (m_state == 0) m_state = 1;
      start = 1'b1;
      tick();
      start = 1'b0;
      check_all("start", 0, 0, 0, e_win);
   endtask

   task automatic do_move(input int s, input int d);
      int e_ok;
      int e_ill;
      int e_win;
      e_ok  = 0;
      e_ill = 0;
      e_win = (m_state == 2);
      if (m_state == 1) begin
         if (model_move(s, d)) begin
            e_ok = 1;
            if (m_count < CNT_MAX) m_count++;
            if (m_home[0] == 13 && m_home[1] == 13 && m_home[2] == 13 && m_home[3] == 13)
               m_state = 2;
         end else begin
            e_ill = 1;
         end
      end
      move_valid = 1'b1;
      source     = SW'(s);
      dest       = SW'(d);
      tick();
      move_valid = 1'b0;
      check_all($sformatf("move %0d->%0d", s, d), e_ok, e_ill, 0, e_win);
   endtask

   initial begin
      n_tests    = 0;
      n_fail     = 0;
      reset      = 1'b0;
      load_valid = 1'b0;
      load_col   = '0;
      load_card  = '0;
      start      = 1'b0;
      move_valid = 1'b0;
      source     = '0;
      dest       = '0;
      model_reset();

      // Directed rule checks
      do_reset();
      do_load(0, 'h02);            // C2
      do_load(0, 'h01);            // C1 on top
      do_load(1, 'h25);            // H5
      do_load(2, 'h36);            // S6
      do_load(3, 'h19);            // D9
      do_load(3, 'h18);            // D8 on top
      do_move(0, HOME);            // ignored in LOAD
      do_start();
      do_move(0, HOME);
      do_move(0, HOME);
      check("home_clubs_count", 32'(move_count), 32'd2);
      do_move(1, 2);               // H5 onto S6
      do_move(1, 2);               // empty source
      do_move(2, 3);               // H5 onto D8
      do_move(3, 4);               // D8 to empty cell0
      do_move(3, 4);               // cell0 occupied
      do_move(3, 5);               // D9 to cell1
      do_move(5, HOME);            // D9 home on empty diamonds
      do_move(HOME, 0);            // source is home
      do_move(2, 2);               // source == dest
      do_move(2, HOME + 1);        // out-of-range dest
      do_move(HOME + 1, 0);        // out-of-range source
      check("count_after_illegal", 32'(move_count), 32'd5);
      do_load(0, 'h05);            // ignored in PLAY
      do_start();                  // ignored in PLAY
      do_move(4, 0);               // D8 onto empty column

      // Load boundaries
      do_reset();
      for (int i = 0; i <= int'(DEP); i++) begin
         do_load(0, (i % 13) + 1);
         check($sformatf("depth_err_%0d", i), 32'(load_err), 32'(i == int'(DEP)));
      end
      do_load(NC, 'h01);
      do_load(1, 'h00);
      do_load(1, 'h0E);
      do_load(1, 'h3D);
      do_move(1, HOME);

      // Randomised deals and moves
      for (int round = 0; round < 3; round++) begin
         do_reset();
         for (int i = 0; i < 52; i++) deck[i] = ((i / 13) << 4) | ((i % 13) + 1);
         for (int i = 51; i > 0; i--) begin
            rj = int'($urandom_range(i, 0));
            rt = deck[i];
            deck[i] = deck[rj];
            deck[rj] = rt;
         end
         for (int i = 0; i < 52; i++) begin
            rc = int'($urandom_range(NC, 0));
            if ($urandom_range(15, 0) == 0)
               do_load(rc, int'($urandom_range(63, 0)));
            do_load(rc, deck[i]);
         end
         do_start();
         for (int k = 0; k < 300; k++) begin
            rs = int'($urandom_range(HOME + 1, 0));
            rd = ($urandom_range(1, 0) == 1) ? HOME : int'($urandom_range(HOME + 1, 0));
            do_move(rs, rd);
         end
      end

      // Counter saturation by shuttling one card between the cells
      do_reset();
      do_load(0, 'h01);
      do_start();
      do_move(0, 4);
      for (int i = 0; i < CNT_MAX + 4; i++) begin
         if (i % 2 == 0) do_move(4, 5);
         else            do_move(5, 4);
      end
      check("count_saturated", 32'(move_count), 32'(CNT_MAX));

      // Full sorted deal played to a win
      do_reset();
      for (int s = 0; s < 4; s++)
         for (int r = 13; r >= 1; r--)
            do_load(s, (s << 4) | r);
      do_start();
      for (int r = 1; r <= 13; r++)
         for (int s = 0; s < 4; s++)
            do_move(s, HOME);
      check("win_lags_last_move", 32'(win), 32'd0);
      check("count_52", 32'(move_count), 32'd52);
      do_move(0, 1);               // ignored in WIN
      check("win_set", 32'(win), 32'd1);
      do_start();                  // ignored in WIN
      do_load(0, 'h01);            // ignored in WIN
      do_reset();                  // async reset clears win at once

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
